id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
// Parametrised ID->EX pipeline register with valid/ready flow control.
// Adds stall back-pressure, flush/bubble insertion and a 2-entry skid buffer so id_ready is registered.
// Sits between decode (operand muxes, control decode) and the ALU/data-memory stage.
// Counts EX back-pressure cycles for performance debug.
// PARAMETERS
// DATA_W      32  width of muxA, muxB and next_pc
// IMM_W       16  immediate width
// ALU_OP_W    5   ALU opcode width
// SEL_W       2   width of rf_d_sel and rd_sel
// STALL_CNT_W 16  width of the saturating stall counter
// PORTS
// clk            in   1         clock, all logic on rising edge
// rst_n          in   1         synchronous reset, active low
// flush          in   1         kill all held and incoming instructions
// id_valid       in   1         ID presents an instruction
// id_ready       out  1         stage can accept (registered)
// id_ret_enable  in   1         return-enable control
// id_rf_d_sel    in   SEL_W     register-file data select
// id_dm_we       in   1         data-memory write enable
// id_rd_sel      in   SEL_W     destination select
// id_alu_op      in   ALU_OP_W  ALU operation
// id_dm_addr_sel in   1         data-memory address select
// id_immediate   in   IMM_W     immediate field
// id_mux_a       in   DATA_W    operand A
// id_mux_b       in   DATA_W    operand B
// id_next_pc     in   DATA_W    PC+1 of instruction
// ex_valid       out  1         EX holds a valid instruction
// ex_ready       in   1         EX consumes this cycle
// ex_*           out  (same)    registered copies of every id_* field above
// stall_cnt      out  STALL_CNT_W  cycles with ex_valid=1 and ex_ready=0
// BEHAVIOUR
// - Reset (rst_n=0 at edge): ex_valid=0, skid empty, id_ready=1, all ex_* fields=0, stall_cnt=0.
// - Accept = id_valid & id_ready; Consume = ex_valid & ex_ready. Evaluated at the same edge.
// - Storage: main reg (drives ex_*) + skid reg. States: EMPTY, ONE (main valid), TWO (main+skid valid).
// - EMPTY: Accept -> ONE, main<=input (latency 1 cycle ID->EX).
// - ONE: Accept&Consume -> ONE, main<=input; Accept&!Consume -> TWO, skid<=input;
//   !Accept&Consume -> EMPTY; else hold.
// - TWO: Consume -> ONE, main<=skid (Accept impossible, id_ready=0); else hold.
// - id_ready is a register = (next state != TWO); it may deassert one cycle after
//   main stalls; skid absorbs the one in-flight instruction. No loss, no duplication.
// - flush=1 at edge: next state EMPTY, ex_valid=0, id_ready=1; incoming instruction dropped
//   even if Accept; flush has priority over Accept, Consume and stall.
// - Bubble qualification: ex_dm_we and ex_ret_enable are driven 0 whenever ex_valid=0.
//   Other ex_* fields hold last value when invalid (don't-care to EX).
// - Field registers load only on their own load enable (no toggling on bubbles).
// - stall_cnt: +1 per cycle with ex_valid & !ex_ready; saturates at all-ones; cleared only by reset.
// - Reset mid-operation: all held instructions discarded, same as reset values above.
// - Order within the stage is strict FIFO.
// STRUCTURE
// - cpu_pkg: typedef struct packed id_ex_bundle_t {ret_enable, rf_d_sel, dm_we, rd_sel, alu_op,
//   dm_addr_sel, immediate, mux_a, mux_b, next_pc} sized by the parameters; typedef enum
//   pipe_state_e {PS_EMPTY, PS_ONE, PS_TWO}.
// - One generic sub-module pipe_skid_buffer #(type T) holding state, main/skid regs, handshake;
//   top level packs/unpacks the bundle, applies bubble gating and the stall counter.
// TESTING
// - Reset: rst_n=0 two cycles with id_valid=1 -> ex_valid=0, id_ready=1, ex_mux_a=0, stall_cnt=0.
// - Streaming: ex_ready=1, 4 back-to-back instrs mux_a=1..4 -> ex_mux_a 1,2,3,4 on cycles 1..4, no gaps.
// - Back-pressure: ex_ready=0 after instr 1, id_valid held -> instr 2 in skid, id_ready=0 next cycle;
//   ex_ready=1 after 3 stall cycles -> 1,2,3 emerge in order, stall_cnt=3.
// - Flush in TWO with id_valid=1, id_dm_we=1 -> next cycle ex_valid=0, ex_dm_we=0, id_ready=1;
//   next instr mux_a=9 appears 1 cycle after accept.
// - Bubble gating: accept instr dm_we=1, ret_enable=1, then id_valid=0 -> after consume ex_dm_we=0, ex_ret_enable=0.
// - Saturation: STALL_CNT_W=4, ex_ready=0 for 20 cycles -> stall_cnt sticks at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the ID->EX pipeline register.
package cpu_pkg;

    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_IMM_W       = 16;
    localparam int unsigned DEF_ALU_OP_W    = 5;
    localparam int unsigned DEF_SEL_W       = 2;
    localparam int unsigned DEF_STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic two-entry valid/ready stage with a registered input ready.
// The skid entry catches the one instruction already in flight when the output stalls.
module pipe_skid_buffer
    import cpu_pkg::*;
#(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    pipe_state_e state_q;
    logic        ready_q;
    T            main_q;
    T            skid_q;

    logic accept;
    logic consume;

    assign accept    = in_valid & ready_q;
    assign consume   = (state_q != PS_EMPTY) & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (state_q != PS_EMPTY);
    assign out_data  = main_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PS_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            // Data registers keep their contents; only occupancy is discarded.
            state_q <= PS_EMPTY;
            ready_q <= 1'b1;
        end else begin
            ready_q <= 1'b1;
            unique case (state_q)
                PS_EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data;
                        state_q <= PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (accept && consume) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q  <= in_data;
                        state_q <= PS_TWO;
                        ready_q <= 1'b0;
                    end else if (consume) begin
                        state_q <= PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    if (consume) begin
                        main_q  <= skid_q;
                        state_q <= PS_ONE;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= PS_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: packs decode fields into one bundle, gates side-effecting
// controls on bubbles and counts EX back-pressure cycles.
module id_ex_pipe_reg
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned IMM_W       = DEF_IMM_W,
    parameter int unsigned ALU_OP_W    = DEF_ALU_OP_W,
    parameter int unsigned SEL_W       = DEF_SEL_W,
    parameter int unsigned STALL_CNT_W = DEF_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic                   id_ret_enable,
    input  logic [SEL_W-1:0]       id_rf_d_sel,
    input  logic                   id_dm_we,
    input  logic [SEL_W-1:0]       id_rd_sel,
    input  logic [ALU_OP_W-1:0]    id_alu_op,
    input  logic                   id_dm_addr_sel,
    input  logic [IMM_W-1:0]       id_immediate,
    input  logic [DATA_W-1:0]      id_mux_a,
    input  logic [DATA_W-1:0]      id_mux_b,
    input  logic [DATA_W-1:0]      id_next_pc,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic                   ex_ret_enable,
    output logic [SEL_W-1:0]       ex_rf_d_sel,
    output logic                   ex_dm_we,
    output logic [SEL_W-1:0]       ex_rd_sel,
    output logic [ALU_OP_W-1:0]    ex_alu_op,
    output logic                   ex_dm_addr_sel,
    output logic [IMM_W-1:0]       ex_immediate,
    output logic [DATA_W-1:0]      ex_mux_a,
    output logic [DATA_W-1:0]      ex_mux_b,
    output logic [DATA_W-1:0]      ex_next_pc,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Sized by this instance's parameters, so it lives here rather than in cpu_pkg.
    typedef struct packed {
        logic                ret_enable;
        logic [SEL_W-1:0]    rf_d_sel;
        logic                dm_we;
        logic [SEL_W-1:0]    rd_sel;
        logic [ALU_OP_W-1:0] alu_op;
        logic                dm_addr_sel;
        logic [IMM_W-1:0]    immediate;
        logic [DATA_W-1:0]   mux_a;
        logic [DATA_W-1:0]   mux_b;
        logic [DATA_W-1:0]   next_pc;
    } id_ex_bundle_t;

    id_ex_bundle_t in_bundle;
    id_ex_bundle_t out_bundle;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    assign in_bundle = {id_ret_enable, id_rf_d_sel, id_dm_we, id_rd_sel, id_alu_op,
                        id_dm_addr_sel, id_immediate, id_mux_a, id_mux_b, id_next_pc};

    pipe_skid_buffer #(
        .T(id_ex_bundle_t)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (id_valid),
        .in_ready (id_ready),
        .in_data  (in_bundle),
        .out_valid(ex_valid),
        .out_ready(ex_ready),
        .out_data (out_bundle)
    );

    // Only the fields with side effects in EX need squashing on a bubble.
    assign ex_ret_enable  = out_bundle.ret_enable & ex_valid;
    assign ex_dm_we       = out_bundle.dm_we & ex_valid;
    assign ex_rf_d_sel    = out_bundle.rf_d_sel;
    assign ex_rd_sel      = out_bundle.rd_sel;
    assign ex_alu_op      = out_bundle.alu_op;
    assign ex_dm_addr_sel = out_bundle.dm_addr_sel;
    assign ex_immediate   = out_bundle.immediate;
    assign ex_mux_a       = out_bundle.mux_a;
    assign ex_mux_b       = out_bundle.mux_b;
    assign ex_next_pc     = out_bundle.next_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (ex_valid && !ex_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomised bench for id_ex_pipe_reg against a queue-based FIFO model of the stage.
module tb_id_ex_pipe_reg;

    localparam int W = 124;

    logic clk = 1'b0;
    logic rst_n, flush, id_valid, ex_ready;
    logic [W-1:0] in_vec;

    logic        id_ready, ex_valid;
    logic        id_ret_enable, id_dm_we, id_dm_addr_sel;
    logic [1:0]  id_rf_d_sel, id_rd_sel;
    logic [4:0]  id_alu_op;
    logic [15:0] id_immediate;
    logic [31:0] id_mux_a, id_mux_b, id_next_pc;
    logic        ex_ret_enable, ex_dm_we, ex_dm_addr_sel;
    logic [1:0]  ex_rf_d_sel, ex_rd_sel;
    logic [4:0]  ex_alu_op;
    logic [15:0] ex_immediate;
    logic [31:0] ex_mux_a, ex_mux_b, ex_next_pc;
    logic [15:0] stall_cnt;
    logic [W-1:0] ex_vec;

    logic        s_id_ready, s_ex_valid, s_ret, s_dm_we, s_dm_addr_sel;
    logic [1:0]  s_rf_d_sel, s_rd_sel;
    logic [4:0]  s_alu_op;
    logic [15:0] s_imm;
    logic [31:0] s_a, s_b, s_pc;
    logic [3:0]  s_stall_cnt;

    assign {id_ret_enable, id_rf_d_sel, id_dm_we, id_rd_sel, id_alu_op, id_dm_addr_sel,
            id_immediate, id_mux_a, id_mux_b, id_next_pc} = in_vec;
    assign ex_vec = {ex_ret_enable, ex_rf_d_sel, ex_dm_we, ex_rd_sel, ex_alu_op, ex_dm_addr_sel,
                     ex_immediate, ex_mux_a, ex_mux_b, ex_next_pc};

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_ret_enable(id_ret_enable), .id_rf_d_sel(id_rf_d_sel), .id_dm_we(id_dm_we),
        .id_rd_sel(id_rd_sel), .id_alu_op(id_alu_op), .id_dm_addr_sel(id_dm_addr_sel),
        .id_immediate(id_immediate), .id_mux_a(id_mux_a), .id_mux_b(id_mux_b),
        .id_next_pc(id_next_pc), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_ret_enable(ex_ret_enable), .ex_rf_d_sel(ex_rf_d_sel), .ex_dm_we(ex_dm_we),
        .ex_rd_sel(ex_rd_sel), .ex_alu_op(ex_alu_op), .ex_dm_addr_sel(ex_dm_addr_sel),
        .ex_immediate(ex_immediate), .ex_mux_a(ex_mux_a), .ex_mux_b(ex_mux_b),
        .ex_next_pc(ex_next_pc), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    id_ex_pipe_reg #(.STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(s_id_ready),
        .id_ret_enable(id_ret_enable), .id_rf_d_sel(id_rf_d_sel), .id_dm_we(id_dm_we),
        .id_rd_sel(id_rd_sel), .id_alu_op(id_alu_op), .id_dm_addr_sel(id_dm_addr_sel),
        .id_immediate(id_immediate), .id_mux_a(id_mux_a), .id_mux_b(id_mux_b),
        .id_next_pc(id_next_pc), .ex_valid(s_ex_valid), .ex_ready(ex_ready),
        .ex_ret_enable(s_ret), .ex_rf_d_sel(s_rf_d_sel), .ex_dm_we(s_dm_we),
        .ex_rd_sel(s_rd_sel), .ex_alu_op(s_alu_op), .ex_dm_addr_sel(s_dm_addr_sel),
        .ex_immediate(s_imm), .ex_mux_a(s_a), .ex_mux_b(s_b),
        .ex_next_pc(s_pc), .stall_cnt(s_stall_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] m_q[$];
    logic [W-1:0] m_shown;
    logic         m_ready;
    int           m_stalls;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] make_item(input logic [31:0] a, input bit dm, input bit ret);
        logic [127:0] r;
        logic [W-1:0] v;
        r = {$urandom, $urandom, $urandom, $urandom};
        v = r[W-1:0];
        v[95:64] = a;
        v[120]   = dm;
        v[123]   = ret;
        return v;
    endfunction

    // FIFO view of the stage: head is what EX sees, capacity two, ready reflects free room.
    task automatic model_edge();
        if (!rst_n) begin
            m_q.delete();
            m_ready  = 1'b1;
            m_shown  = '0;
            m_stalls = 0;
        end else begin
            if (m_q.size() > 0 && !ex_ready) m_stalls++;
            if (flush) begin
                m_q.delete();
                m_ready = 1'b1;
            end else begin
                bit acc, con;
                acc = id_valid && m_ready;
                con = (m_q.size() > 0) && ex_ready;
                if (con) void'(m_q.pop_front());
                if (acc) m_q.push_back(in_vec);
                m_ready = (m_q.size() < 2);
                if (m_q.size() > 0) m_shown = m_q[0];
            end
        end
    endtask

    task automatic compare_all();
        logic [W-1:0] e;
        bit v;
        v = (m_q.size() > 0);
        e = m_shown;
        if (!v) begin
            e[123] = 1'b0;
            e[120] = 1'b0;
        end
        check("ex_valid", {127'b0, ex_valid}, {127'b0, v});
        check("id_ready", {127'b0, id_ready}, {127'b0, m_ready});
        check("ex_fields", {4'b0, ex_vec}, {4'b0, e});
        check("stall_cnt", {112'b0, stall_cnt}, 128'(m_stalls > 65535 ? 65535 : m_stalls));
        check("stall_cnt_w4", {124'b0, s_stall_cnt}, 128'(m_stalls > 15 ? 15 : m_stalls));
        check("sat_ex_valid", {127'b0, s_ex_valid}, {127'b0, v});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b1; ex_ready = 1'b0;
        in_vec = make_item(32'hdead, 1'b1, 1'b1);
        step();
        step();
        check("rst_mux_a", {96'b0, ex_mux_a}, 128'd0);
        check("rst_ex_valid", {127'b0, ex_valid}, 128'd0);
        rst_n = 1'b1;

        // Back-to-back streaming.
        ex_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            id_valid = 1'b1;
            in_vec = make_item(32'(i), 1'b0, 1'b0);
            step();
            check("stream_mux_a", {96'b0, ex_mux_a}, 128'(i));
        end
        id_valid = 1'b0;
        step();

        // Back-pressure into the skid entry.
        ex_ready = 1'b1; id_valid = 1'b1; in_vec = make_item(32'd1, 1'b0, 1'b0);
        step();
        ex_ready = 1'b0; in_vec = make_item(32'd2, 1'b0, 1'b0);
        step();
        check("bp_id_ready", {127'b0, id_ready}, 128'd0);
        in_vec = make_item(32'd3, 1'b0, 1'b0);
        step();
        step();
        ex_ready = 1'b1;
        step();
        check("bp_second", {96'b0, ex_mux_a}, 128'd2);
        step();
        check("bp_third", {96'b0, ex_mux_a}, 128'd3);
        id_valid = 1'b0;
        step();
        check("bp_stall_cnt", {112'b0, stall_cnt}, 128'd3);

        // Flush while full, with a store presented.
        ex_ready = 1'b0; id_valid = 1'b1; in_vec = make_item(32'd5, 1'b0, 1'b0);
        step();
        in_vec = make_item(32'd6, 1'b0, 1'b0);
        step();
        flush = 1'b1; in_vec = make_item(32'd7, 1'b1, 1'b0);
        step();
        check("flush_dm_we", {127'b0, ex_dm_we}, 128'd0);
        flush = 1'b0; ex_ready = 1'b1; in_vec = make_item(32'd9, 1'b0, 1'b0);
        step();
        check("flush_next", {96'b0, ex_mux_a}, 128'd9);

        // Bubble gating of side-effecting controls.
        in_vec = make_item(32'd10, 1'b1, 1'b1);
        step();
        check("bubble_pre_we", {127'b0, ex_dm_we}, 128'd1);
        id_valid = 1'b0;
        step();
        check("bubble_we", {127'b0, ex_dm_we}, 128'd0);
        check("bubble_ret", {127'b0, ex_ret_enable}, 128'd0);

        // Long stall for counter saturation.
        id_valid = 1'b1; in_vec = make_item(32'd11, 1'b0, 1'b0);
        step();
        ex_ready = 1'b0; id_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt", {124'b0, s_stall_cnt}, 128'd15);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            id_valid = ($urandom_range(0, 9) < 7);
            ex_ready = ($urandom_range(0, 9) < 6);
            in_vec   = make_item($urandom, 1'($urandom), 1'($urandom));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
